// File: rtl/d_waveform_gen_if.sv
// Host/flip-flop side bundle for d_waveform_gen: segment loading, start,
// D drive, Q return and status.
interface d_waveform_gen_if #(
    parameter int unsigned CNT_W = 8
);
    logic             seg_valid;
    logic             seg_ready;
    logic             seg_level;
    logic [CNT_W-1:0] seg_len;
    logic             start;
    logic             D_out;
    logic             q_in;
    logic             busy;
    logic             done;
    logic [7:0]       mismatch_cnt;

    modport slave (
        input  seg_valid, seg_level, seg_len, start, q_in,
        output seg_ready, D_out, busy, done, mismatch_cnt
    );

    modport master (
        output seg_valid, seg_level, seg_len, start, q_in,
        input  seg_ready, D_out, busy, done, mismatch_cnt
    );
endinterface

// File: rtl/d_waveform_gen.sv
// Segment-programmed D stimulus generator with a Q checker that counts
// mismatches against its own one-cycle-delayed drive.
module d_waveform_gen #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned CNT_W = 8
) (
    input logic            clkin,
    input logic            rst_n,
    d_waveform_gen_if.slave bus
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW-1:0]    PtrOne  = AW'(1);
    localparam logic [AW:0]      CntOne  = (AW + 1)'(1);
    localparam logic [AW:0]      CntFull = (AW + 1)'(DEPTH);
    localparam logic [CNT_W-1:0] HoldOne = CNT_W'(1);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e           state_q;
    logic [DEPTH-1:0] lvl_mem_q;
    logic [CNT_W-1:0] len_mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [AW:0]      count_q;
    logic [CNT_W-1:0] hold_q;
    logic             d_out_q, busy_q, done_q;
    logic             d_prev_q, chk_en_q;
    logic [7:0]       mis_q;

    logic full, empty, seg_ready, push, pop, start_acc, seg_last;

    assign full      = (count_q == CntFull);
    assign empty     = (count_q == '0);
    assign seg_ready = (state_q == StIdle) && !full;
    // Zero-length segments complete the handshake but are dropped.
    assign push      = bus.seg_valid && seg_ready && (bus.seg_len != '0);
    assign start_acc = (state_q == StIdle) && bus.start && !empty;
    // hold_q is 0 on the entry cycle of RUN, so the first pop happens one edge after start.
    assign seg_last  = (hold_q <= HoldOne);
    assign pop       = (state_q == StRun) && seg_last && !empty;

    assign bus.seg_ready    = seg_ready;
    assign bus.D_out        = d_out_q;
    assign bus.busy         = busy_q;
    assign bus.done         = done_q;
    assign bus.mismatch_cnt = mis_q;

    always_ff @(posedge clkin) begin
        if (push) begin
            lvl_mem_q[wr_ptr_q] <= bus.seg_level;
            len_mem_q[wr_ptr_q] <= bus.seg_len;
        end
    end

    always_ff @(posedge clkin or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            hold_q   <= '0;
            d_out_q  <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            d_prev_q <= 1'b0;
            chk_en_q <= 1'b0;
            mis_q    <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + PtrOne;
            if (pop)  rd_ptr_q <= rd_ptr_q + PtrOne;
            if (push && !pop)      count_q <= count_q + CntOne;
            else if (pop && !push) count_q <= count_q - CntOne;

            done_q <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (start_acc) begin
                        state_q <= StRun;
                        hold_q  <= '0;
                    end
                end
                StRun: begin
                    if (!seg_last) begin
                        hold_q <= hold_q - HoldOne;
                    end else if (!empty) begin
                        d_out_q <= lvl_mem_q[rd_ptr_q];
                        hold_q  <= len_mem_q[rd_ptr_q];
                        busy_q  <= 1'b1;
                    end else begin
                        state_q <= StDone;
                        d_out_q <= 1'b0;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end
                end
                StDone:  state_q <= StIdle;
                default: state_q <= StIdle;
            endcase

            // Q lags D by one flop, so compare against last cycle's drive.
            d_prev_q <= d_out_q;
            chk_en_q <= busy_q;
            if (start_acc) begin
                mis_q <= '0;
            end else if (chk_en_q && (bus.q_in != d_prev_q) && (mis_q != 8'hFF)) begin
                mis_q <= mis_q + 8'd1;
            end
        end
    end
endmodule

// File: tb/tb_d_waveform_gen.sv
// Directed bench for d_waveform_gen: expected D_out stream is queued as
// segments are loaded and popped cycle by cycle during playback.
module tb_d_waveform_gen;
    localparam int unsigned DEPTH = 8;
    localparam int unsigned CNT_W = 8;

    logic clkin = 1'b0;
    logic rst_n = 1'b0;

    d_waveform_gen_if #(.CNT_W(CNT_W)) bus ();

    d_waveform_gen #(
        .DEPTH(DEPTH),
        .CNT_W(CNT_W)
    ) dut (
        .clkin(clkin),
        .rst_n(rst_n),
        .bus  (bus)
    );

    always #5 clkin = ~clkin;

    int          n_assert = 0;
    int          n_fail   = 0;
    int unsigned q_mode   = 0;  // 0: ideal DFF of D_out, 1: stuck 0, 2: stuck 1
    logic        dff_q    = 1'b0;
    logic        exp_q[$];

    always @(posedge clkin) dff_q <= bus.D_out;
    assign bus.q_in = (q_mode == 0) ? dff_q : (q_mode == 2);

    logic std_lvl[7] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    int   std_len[7] = '{9, 7, 4, 10, 5, 3, 7};

    task automatic step();
        @(posedge clkin);
        #1;
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic push_seg(input logic lvl, input int len);
        int t = 0;
        bus.seg_valid = 1'b1;
        bus.seg_level = lvl;
        bus.seg_len   = len[CNT_W-1:0];
        while (!bus.seg_ready && t < 50) begin
            step();
            t++;
        end
        chk1("push_ready", bus.seg_ready, 1'b1);
        step();
        bus.seg_valid = 1'b0;
        for (int i = 0; i < len; i++) exp_q.push_back(lvl);
    endtask

    task automatic load_std();
        for (int i = 0; i < 7; i++) push_seg(std_lvl[i], std_len[i]);
    endtask

    // Plays the queued segments; optionally pulses start/seg_valid at cycle pulse_at.
    task automatic play(input string tag, input logic [7:0] exp_mis, input int pulse_at);
        int n;
        logic e;
        n = exp_q.size();
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        chk1({tag, "_lat_busy"}, bus.busy, 1'b0);
        chk1({tag, "_lat_d"}, bus.D_out, 1'b0);
        for (int i = 0; i < n; i++) begin
            if (i == pulse_at) begin
                bus.start     = 1'b1;
                bus.seg_valid = 1'b1;
                bus.seg_level = 1'b1;
                bus.seg_len   = 8'd3;
            end
            step();
            if (i == pulse_at) begin
                bus.start     = 1'b0;
                bus.seg_valid = 1'b0;
            end
            e = exp_q.pop_front();
            chk1({tag, "_d"}, bus.D_out, e);
            chk1({tag, "_busy"}, bus.busy, 1'b1);
        end
        step();
        chk1({tag, "_done"}, bus.done, 1'b1);
        chk1({tag, "_done_busy"}, bus.busy, 1'b0);
        chk1({tag, "_done_d"}, bus.D_out, 1'b0);
        step();
        chk1({tag, "_done_pulse"}, bus.done, 1'b0);
        chk1({tag, "_idle_ready"}, bus.seg_ready, 1'b1);
        chk8({tag, "_mis"}, bus.mismatch_cnt, exp_mis);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.seg_valid = 1'b0;
        bus.seg_level = 1'b0;
        bus.seg_len   = '0;
        bus.start     = 1'b0;

        step();
        step();
        chk1("rst_d", bus.D_out, 1'b0);
        chk1("rst_busy", bus.busy, 1'b0);
        chk1("rst_done", bus.done, 1'b0);
        chk8("rst_mis", bus.mismatch_cnt, 8'd0);
        rst_n = 1'b1;
        step();
        chk1("rst_ready", bus.seg_ready, 1'b1);

        // Ideal loopback, with start/seg_valid pulsed mid-run (must be ignored).
        q_mode = 0;
        load_std();
        play("ideal", 8'd0, 5);

        // Q stuck at 0: one mismatch per 1-level cycle.
        q_mode = 1;
        load_std();
        play("q0", 8'd20, -1);

        // Fill all entries, then hold a 9th offer across the run.
        q_mode = 0;
        for (int i = 0; i < 8; i++) push_seg(logic'(i % 2), i + 1);
        chk1("full_ready", bus.seg_ready, 1'b0);
        bus.seg_valid = 1'b1;
        bus.seg_level = 1'b1;
        bus.seg_len   = 8'd2;
        play("full", 8'd0, -1);
        step();
        bus.seg_valid = 1'b0;
        chk1("ninth_ready", bus.seg_ready, 1'b1);
        exp_q.push_back(1'b1);
        exp_q.push_back(1'b1);
        play("ninth", 8'd0, -1);

        // Zero-length segment: handshake completes, nothing stored.
        push_seg(1'b1, 0);
        chk1("zlen_ready", bus.seg_ready, 1'b1);
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        step();
        chk1("zlen_busy", bus.busy, 1'b0);
        chk1("zlen_d", bus.D_out, 1'b0);
        step();
        chk1("zlen_done", bus.done, 1'b0);

        // Reset mid-segment while mismatches are accumulating.
        q_mode = 2;
        push_seg(1'b0, 20);
        push_seg(1'b1, 5);
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        for (int i = 0; i < 8; i++) step();
        chk8("pre_rst_mis", bus.mismatch_cnt, 8'd6);
        chk1("pre_rst_busy", bus.busy, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        chk1("mid_rst_d", bus.D_out, 1'b0);
        chk1("mid_rst_busy", bus.busy, 1'b0);
        chk1("mid_rst_done", bus.done, 1'b0);
        chk8("mid_rst_mis", bus.mismatch_cnt, 8'd0);
        #1;
        rst_n = 1'b1;
        exp_q.delete();
        step();
        chk1("post_rst_ready", bus.seg_ready, 1'b1);
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        step();
        chk1("post_rst_busy", bus.busy, 1'b0);
        chk1("post_rst_d", bus.D_out, 1'b0);

        // Q stuck at 1 across 300 zero cycles: counter saturates.
        push_seg(1'b0, 200);
        push_seg(1'b0, 100);
        play("sat", 8'd255, -1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
